siren_driver: RTL and testbench
===============================

Name: siren_driver

Overview:
- Downstream stage of the car-alarm FSM. Consumes its level-type `alarm` output and drives the physical siren and hazard lamp with a timed on/off burst pattern.
- Limits noise: after a fixed number of bursts the siren is silenced, while the lamp stays lit until `alarm` drops.
- Purely synchronous. One clock, synchronous active-low reset.

Parameters:
- ON_CYC, 4, clock cycles siren/lamp high per burst (>=1)
- OFF_CYC, 4, clock cycles siren/lamp low between bursts (>=1)
- MAX_BURSTS, 8, bursts before silencing (1 .. 2^BW-1)
- CW, 16, phase counter width; ON_CYC and OFF_CYC must each be <= 2^CW
- BW, 4, burst counter width

Ports:
- clk  input  1  system clock; all state updates on rising edge
- rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
- alarm  input  1  level from alarm FSM; 1 = intrusion alarm active
- siren  output  1  siren drive, 1 = sounding
- lamp  output  1  hazard lamp drive
- silenced  output  1  1 = burst limit reached, siren muted, alarm still active
- burst_cnt  output  BW  completed bursts in the current alarm episode

Behaviour:
- Reset: rst==0 at a rising edge forces state IDLE, phase=0, burst_cnt=0, siren=0, lamp=0, silenced=0. Reset has priority over all other inputs, including mid-burst and in HOLD.
- Moore machine. Outputs are decoded from the registered state only, so there is no combinational path from alarm to any output.
- States and outputs (siren/lamp/silenced):
  - IDLE 0/0/0
  - ON 1/1/0
  - OFF 0/0/0
  - HOLD 0/1/1
- Transitions, evaluated at each rising edge with rst==1:
  - IDLE: alarm==1 -> ON, phase=0, burst_cnt=0. Otherwise stay.
  - ON:
    - alarm==0 -> IDLE.
    - else phase==ON_CYC-1 -> OFF, phase=0, burst_cnt+1.
    - else phase+1.
  - OFF:
    - alarm==0 -> IDLE.
    - else phase==OFF_CYC-1 and burst_cnt==MAX_BURSTS -> HOLD.
    - else phase==OFF_CYC-1 -> ON, phase=0.
    - else phase+1.
  - HOLD: alarm==0 -> IDLE. Otherwise stay; counters frozen.
- Priority: alarm==0 beats any phase or burst transition in the same cycle.
- Leaving to IDLE clears phase. burst_cnt is held until the next IDLE->ON, where it is cleared.
- Latency:
  - alarm sampled 1 at edge k -> siren=1 from edge k onward, i.e. 1 cycle after alarm is registered.
  - alarm sampled 0 at edge k -> all outputs 0 after edge k.
- Timing: ON lasts exactly ON_CYC cycles and OFF exactly OFF_CYC cycles. From entry to ON until entry to HOLD is MAX_BURSTS*(ON_CYC+OFF_CYC) cycles.
- burst_cnt never exceeds MAX_BURSTS; no wrap-around is possible given the parameter constraints.
- Re-assertion: alarm 1->0->1 starts a fresh episode with full bursts, including after HOLD.
- A one-cycle alarm pulse gives one cycle in ON, then IDLE.

Test Plan:
- Reset: hold rst=0 for 3 cycles with alarm=1 -> siren=lamp=silenced=0, burst_cnt=0. Release rst -> siren=1 after the next edge.
- Burst pattern (ON_CYC=4, OFF_CYC=4, MAX_BURSTS=3): alarm held 1 -> siren sequence 1111 0000 repeated 3 times. burst_cnt steps 1,2,3 on each ON->OFF edge. After 24 cycles: siren=0, lamp=1, silenced=1, burst_cnt=3; stays so for 20 more cycles.
- Mid-burst drop: alarm falls on the 2nd cycle of the 2nd ON phase -> all outputs 0 on the next edge, state IDLE, burst_cnt holds 1. alarm re-asserted -> burst_cnt=0 and a full new pattern starts.
- HOLD release: from HOLD, drop alarm -> lamp=0, silenced=0 on the next edge. Re-raise alarm -> siren=1 one cycle later.
- Simultaneous events: alarm=0 on the same edge as the final OFF cycle with burst_cnt==MAX_BURSTS -> IDLE, never HOLD. Also rst=0 while alarm=1 in ON -> IDLE.
- Edge parameters (ON_CYC=1, OFF_CYC=1, MAX_BURSTS=1): alarm=1 -> siren 1,0 then HOLD on the 3rd cycle with silenced=1.

Source files
------------

// File: rtl/siren_if.sv
// Alarm-to-siren link: the alarm level going into the siren driver
// and the drive/status signals coming back out of it.
interface siren_if #(
  parameter int unsigned BW = 4
);
  logic          alarm;
  logic          siren;
  logic          lamp;
  logic          silenced;
  logic [BW-1:0] burst_cnt;

  modport master (
    output alarm,
    input  siren,
    input  lamp,
    input  silenced,
    input  burst_cnt
  );

  modport slave (
    input  alarm,
    output siren,
    output lamp,
    output silenced,
    output burst_cnt
  );
endinterface

// File: rtl/siren_driver.sv
// Siren/hazard-lamp burst sequencer. It drives ON/OFF bursts while alarm is high,
// then mutes the siren after MAX_BURSTS bursts and keeps the lamp lit until alarm drops.
module siren_driver #(
  parameter int unsigned ON_CYC     = 4,
  parameter int unsigned OFF_CYC    = 4,
  parameter int unsigned MAX_BURSTS = 8,
  parameter int unsigned CW         = 16,
  parameter int unsigned BW         = 4
) (
  input  logic   clk,
  input  logic   rst,
  siren_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ON   = 2'd1,
    OFF  = 2'd2,
    HOLD = 2'd3
  } state_e;

  localparam logic [CW-1:0] ON_LAST  = CW'(ON_CYC - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(OFF_CYC - 1);
  localparam logic [BW-1:0] BURST_LIM = BW'(MAX_BURSTS);

  state_e        state_q, state_d;
  logic [CW-1:0] phase_q, phase_d;
  logic [BW-1:0] burst_q, burst_d;
  logic          siren_q, siren_d;
  logic          lamp_q, lamp_d;
  logic          silenced_q, silenced_d;

  // Next-state logic. A low alarm wins over any phase or burst step.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    burst_d = burst_q;
    case (state_q)
      IDLE: begin
        if (bus.alarm) begin
          state_d = ON;
          phase_d = {CW{1'b0}};
          burst_d = {BW{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      ON: begin
        if (!bus.alarm) begin
          state_d = IDLE;
          phase_d = {CW{1'b0}};
        end else if (phase_q == ON_LAST) begin
          state_d = OFF;
          phase_d = {CW{1'b0}};
          burst_d = burst_q + {{(BW-1){1'b0}}, 1'b1};
        end else begin
          phase_d = phase_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      OFF: begin
        if (!bus.alarm) begin
          state_d = IDLE;
          phase_d = {CW{1'b0}};
        end else if ((phase_q == OFF_LAST) && (burst_q == BURST_LIM)) begin
          state_d = HOLD;
          phase_d = {CW{1'b0}};
        end else if (phase_q == OFF_LAST) begin
          state_d = ON;
          phase_d = {CW{1'b0}};
        end else begin
          phase_d = phase_q + {{(CW-1){1'b0}}, 1'b1};
        end
      end
      HOLD: begin
        if (!bus.alarm) begin
          state_d = IDLE;
          phase_d = {CW{1'b0}};
        end else begin
          state_d = HOLD;
        end
      end
      default: begin
        state_d = IDLE;
        phase_d = {CW{1'b0}};
        burst_d = {BW{1'b0}};
      end
    endcase
  end

  // Decode outputs from the next state so the flops carry the Moore outputs of state_q.
  always_comb begin
    siren_d    = 1'b0;
    lamp_d     = 1'b0;
    silenced_d = 1'b0;
    case (state_d)
      IDLE:    begin siren_d = 1'b0; lamp_d = 1'b0; silenced_d = 1'b0; end
      ON:      begin siren_d = 1'b1; lamp_d = 1'b1; silenced_d = 1'b0; end
      OFF:     begin siren_d = 1'b0; lamp_d = 1'b0; silenced_d = 1'b0; end
      HOLD:    begin siren_d = 1'b0; lamp_d = 1'b1; silenced_d = 1'b1; end
      default: begin siren_d = 1'b0; lamp_d = 1'b0; silenced_d = 1'b0; end
    endcase
  end

  // State and output registers; the synchronous reset overrides everything.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      phase_q    <= {CW{1'b0}};
      burst_q    <= {BW{1'b0}};
      siren_q    <= 1'b0;
      lamp_q     <= 1'b0;
      silenced_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      phase_q    <= phase_d;
      burst_q    <= burst_d;
      siren_q    <= siren_d;
      lamp_q     <= lamp_d;
      silenced_q <= silenced_d;
    end
  end

  assign bus.siren     = siren_q;
  assign bus.lamp      = lamp_q;
  assign bus.silenced  = silenced_q;
  assign bus.burst_cnt = burst_q;

endmodule

// File: tb/tb_siren_driver.sv
// Directed vector bench for siren_driver: a 4/4/3 instance is driven from a vector table,
// and a 1/1/1 instance is run through a short hand-written sequence.
module tb_siren_driver;

  typedef struct {
    logic       rst;
    logic       alarm;
    logic [6:0] exp;   // {siren, lamp, silenced, burst_cnt}
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_b;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  siren_if #(.BW(4)) if_a ();
  siren_if #(.BW(4)) if_b ();

  siren_driver #(.ON_CYC(4), .OFF_CYC(4), .MAX_BURSTS(3), .CW(16), .BW(4)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (if_a)
  );

  siren_driver #(.ON_CYC(1), .OFF_CYC(1), .MAX_BURSTS(1), .CW(16), .BW(4)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (if_b)
  );

  always #5 clk = ~clk;

  function automatic void add(input logic r, input logic a, input logic s, input logic l,
                              input logic sl, input logic [3:0] c);
    vec_t v;
    v.rst   = r;
    v.alarm = a;
    v.exp   = {s, l, sl, c};
    vecs.push_back(v);
  endfunction

  // Edges t0..t1 of an uninterrupted episode; t=0 is the edge that enters ON.
  // 4 cycles on and 4 cycles off, burst_cnt stepping on each ON->OFF edge, HOLD from t=24.
  function automatic void add_episode(input int t0, input int t1);
    for (int t = t0; t <= t1; t++) begin
      if (t >= 24) add(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3);
      else if ((t % 8) < 4) add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'((t + 4) / 8));
      else add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'((t + 4) / 8));
    end
  endfunction

  task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b, expected %b (siren,lamp,silenced,burst_cnt)", name, act, exp);
    end
  endtask

  task automatic step_b(input logic r, input logic a, input logic [6:0] exp, input string name);
    @(negedge clk);
    rst_b      = r;
    if_b.alarm = a;
    @(posedge clk);
    #1;
    check(name, {if_b.siren, if_b.lamp, if_b.silenced, if_b.burst_cnt}, exp);
  endtask

  initial begin
    rst_a      = 1'b0;
    if_a.alarm = 1'b1;
    rst_b      = 1'b0;
    if_b.alarm = 1'b0;

    // Reset held with alarm high.
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    // Full pattern into HOLD, then 20 more HOLD cycles.
    add_episode(0, 44);
    // HOLD release keeps the count; re-raising starts fresh.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add_episode(0, 9);
    // Drop during the 2nd cycle of the 2nd ON phase.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd1);
    add_episode(0, 23);
    // Drop on the edge that would otherwise enter HOLD.
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd3);
    // Reset while in ON.
    add_episode(0, 1);
    add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0);
    // One-cycle alarm pulse.
    add(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);
    add(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst_a      = vecs[i].rst;
      if_a.alarm = vecs[i].alarm;
      @(posedge clk);
      #1;
      check($sformatf("vec_%0d", i),
            {if_a.siren, if_a.lamp, if_a.silenced, if_a.burst_cnt}, vecs[i].exp);
    end

    // Minimal parameters: one ON cycle, one OFF cycle, then HOLD.
    step_b(1'b0, 1'b1, 7'b000_0000, "b_reset");
    step_b(1'b1, 1'b1, 7'b110_0000, "b_on");
    step_b(1'b1, 1'b1, 7'b000_0001, "b_off");
    step_b(1'b1, 1'b1, 7'b011_0001, "b_hold");
    step_b(1'b1, 1'b1, 7'b011_0001, "b_hold_stay");
    step_b(1'b1, 1'b0, 7'b000_0001, "b_release");
    step_b(1'b1, 1'b1, 7'b110_0000, "b_rearm");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
